// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: arbitrates write/read request streams onto one
// active-low-select SRAM port and returns read data through a
// credit-protected response FIFO.
// Ports: inst_clk/inst_rst (sync, active high); wr_* write request stream;
// rd_* read request stream; rsp_* response stream; sram_* macro interface
// (cs_n, wr_n, addr, din registered; dout registered inside the macro);
// busy = request pending or read in flight.
// Optional: define SRAM_ACCESS_STATS_EN to add stat_clr, stat_wr_cnt and
// stat_rd_cnt (saturating grant counters).
module sram_access_ctrl #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  inst_clk,
  input  logic                  inst_rst,
`ifdef SRAM_ACCESS_STATS_EN
  input  logic                  stat_clr,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt,
`endif
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_cs_n,
  output logic                  sram_wr_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e r_prio;
  prio_e w_prio_nxt;

  logic                  r_cs_n;
  logic                  r_wr_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic                  r_p1;
  logic                  r_p2;

  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [CNT_W-1:0]      w_used;
  logic                  w_credit_ok;
  logic                  w_rd_elig;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;
  logic                  w_push;
  logic                  w_pop;

  // Reads in the pipeline already own a FIFO slot.
  assign w_used      = CNT_W'(r_p1) + CNT_W'(r_p2) + r_count;
  assign w_credit_ok = w_used < CNT_W'(RSP_DEPTH);

  always_comb begin
    w_rd_elig  = rd_valid & w_credit_ok;
    w_gnt_wr   = wr_valid & (~w_rd_elig | (r_prio == PRIO_WR));
    w_gnt_rd   = w_rd_elig & (~wr_valid | (r_prio == PRIO_RD));
    w_prio_nxt = r_prio;
    if (w_gnt_rd) begin
      w_prio_nxt = PRIO_WR;
    end else if (w_gnt_wr && !(rd_valid && !w_credit_ok)) begin
      // A write that only won because reads ran out of credit
      // leaves priority with the starved read stream.
      w_prio_nxt = PRIO_RD;
    end
  end

  always_ff @(posedge inst_clk) begin
    if (inst_rst) r_prio <= PRIO_WR;
    else          r_prio <= w_prio_nxt;
  end

  assign wr_ready = w_gnt_wr;
  assign rd_ready = w_gnt_rd;

  always_ff @(posedge inst_clk) begin
    if (inst_rst) begin
      r_cs_n <= 1'b1;
      r_wr_n <= 1'b1;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_gnt_wr) begin
      r_cs_n <= 1'b0;
      r_wr_n <= 1'b0;
      r_addr <= wr_addr;
      r_din  <= wr_data;
    end else if (w_gnt_rd) begin
      r_cs_n <= 1'b0;
      r_wr_n <= 1'b1;
      r_addr <= rd_addr;
    end else begin
      r_cs_n <= 1'b1;
      r_wr_n <= 1'b1;
    end
  end

  assign sram_cs_n = r_cs_n;
  assign sram_wr_n = r_wr_n;
  assign sram_addr = r_addr;
  assign sram_din  = r_din;

  // p1: command on the SRAM pins; p2: sram_dout valid this cycle.
  always_ff @(posedge inst_clk) begin
    if (inst_rst) begin
      r_p1 <= 1'b0;
      r_p2 <= 1'b0;
    end else begin
      r_p1 <= w_gnt_rd;
      r_p2 <= r_p1;
    end
  end

  assign w_push = r_p2;
  assign w_pop  = (r_count != '0) & rsp_ready;

  always_ff @(posedge inst_clk) begin
    if (w_push) r_mem[r_wptr] <= sram_dout;
  end

  always_ff @(posedge inst_clk) begin
    if (inst_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = r_count != '0;
  assign rsp_data  = r_mem[r_rptr];

  assign busy = wr_valid | rd_valid | r_p1 | r_p2;

`ifdef SRAM_ACCESS_STATS_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  always_ff @(posedge inst_clk) begin
    if (inst_rst || stat_clr) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_gnt_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_gnt_rd && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign stat_wr_cnt = r_wr_cnt;
  assign stat_rd_cnt = r_rd_cnt;
`endif

endmodule
